traffic_light_ctrl: RTL and testbench



---
 rtl/tl_pkg.sv | 52 +++++
 rtl/tl_tick_gen.sv | 38 +++
 rtl/traffic_light_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// tl_pkg - shared definitions for the traffic_light_ctrl intersection sequencer.
//   tl_state_e : 4-bit phase encoding, also driven out on the debug state port
//   LED_*      : bit positions on the 8-bit user LED bank
//   LIGHTS_*   : 7-bit lamp patterns (led[6:0]); the heartbeat bit is added by the top
// Optional night-flash support is selected in the top by the TL_FLASH_EN macro;
// the FLASH encoding stays reserved here in either build.
package tl_pkg;

    typedef enum logic [3:0] {
        NS_GREEN  = 4'd0,
        NS_YELLOW = 4'd1,
        ALL_RED_A = 4'd2,
        EW_GREEN  = 4'd3,
        EW_YELLOW = 4'd4,
        ALL_RED_B = 4'd5,
        PED_WALK  = 4'd6,
        FLASH     = 4'd7
    } tl_state_e;

    localparam int unsigned LED_NS_G      = 0;
    localparam int unsigned LED_NS_Y      = 1;
    localparam int unsigned LED_NS_R      = 2;
    localparam int unsigned LED_EW_G      = 3;
    localparam int unsigned LED_EW_Y      = 4;
    localparam int unsigned LED_EW_R      = 5;
    localparam int unsigned LED_WALK      = 6;
    localparam int unsigned LED_HEARTBEAT = 7;

    // Lamp patterns over led[6:0]
    localparam logic [6:0] LIGHTS_NS_GREEN  = 7'h21; // NS G + EW R
    localparam logic [6:0] LIGHTS_NS_YELLOW = 7'h22; // NS Y + EW R
    localparam logic [6:0] LIGHTS_ALL_RED   = 7'h24; // NS R + EW R
    localparam logic [6:0] LIGHTS_EW_GREEN  = 7'h0C; // NS R + EW G
    localparam logic [6:0] LIGHTS_EW_YELLOW = 7'h14; // NS R + EW Y
    localparam logic [6:0] LIGHTS_PED_WALK  = 7'h64; // NS R + EW R + WALK
    localparam logic [6:0] LIGHTS_FLASH_LIT = 7'h22; // NS Y + EW R, blinking
    localparam logic [6:0] LIGHTS_DARK      = 7'h00;

    // Steady lamp pattern for a phase; FLASH returns its lit half.
    function automatic logic [6:0] lights_for(tl_state_e s);
        case (s)
            NS_GREEN:  return LIGHTS_NS_GREEN;
            NS_YELLOW: return LIGHTS_NS_YELLOW;
            EW_GREEN:  return LIGHTS_EW_GREEN;
            EW_YELLOW: return LIGHTS_EW_YELLOW;
            PED_WALK:  return LIGHTS_PED_WALK;
            FLASH:     return LIGHTS_FLASH_LIT;
            default:   return LIGHTS_ALL_RED;
        endcase
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// tl_tick_gen - 1 s prescaler for traffic_light_ctrl.
//   clk    : fabric clock
//   reset  : synchronous, active-high
//   clr_i  : synchronous clear, restarts the second from zero
//   tick_o : high for one cycle at terminal count CYCLES_PER_SEC-1
module tl_tick_gen #(
    parameter int unsigned CYCLES_PER_SEC = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [W-1:0] TERMINAL = W'(CYCLES_PER_SEC - 1);

    logic [W-1:0] presc_q;
    logic [W-1:0] presc_d;

    assign tick_o = (presc_q == TERMINAL);

    always_comb begin
        presc_d = presc_q + W'(1);
        if (clr_i || tick_o) begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl - two-road intersection sequencer (main NS, side EW) with
// pedestrian walk phase. Phase durations are counted in 1 s ticks.
//   clk      : 100 MHz fabric clock
//   reset    : synchronous, active-high
//   sw_car   : async side-road car sensor (level)
//   sw_ped   : async pedestrian button (rising edge = request)
//   sw_flash : async night-flash select (level), used only with TL_FLASH_EN
//   led      : [0]NS G [1]NS Y [2]NS R [3]EW G [4]EW Y [5]EW R [6]WALK [7]heartbeat
//   state    : current phase encoding (debug)
// Define TL_FLASH_EN to build the night-flash mode; without it sw_flash is ignored.
module traffic_light_ctrl
    import tl_pkg::*;
#(
    parameter int unsigned CYCLES_PER_SEC = 100_000_000,
    parameter int unsigned T_NS_MIN_GREEN = 10,
    parameter int unsigned T_EW_GREEN     = 6,
    parameter int unsigned T_YELLOW       = 3,
    parameter int unsigned T_ALL_RED      = 1,
    parameter int unsigned T_WALK         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_car,
    input  logic       sw_ped,
    input  logic       sw_flash,
    output logic [7:0] led,
    output logic [3:0] state
);

    localparam logic [7:0] LAST_MIN_GREEN = 8'(T_NS_MIN_GREEN - 1);
    localparam logic [7:0] LAST_EW_GREEN  = 8'(T_EW_GREEN - 1);
    localparam logic [7:0] LAST_YELLOW    = 8'(T_YELLOW - 1);
    localparam logic [7:0] LAST_ALL_RED   = 8'(T_ALL_RED - 1);
    localparam logic [7:0] LAST_WALK      = 8'(T_WALK - 1);

    // ---------------------------------------------------------------- inputs
    logic car_s1_q, car_s2_q;
    logic ped_s1_q, ped_s2_q, ped_s3_q;
    logic ped_rise;
    logic flash_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            car_s1_q <= 1'b0;
            car_s2_q <= 1'b0;
            ped_s1_q <= 1'b0;
            ped_s2_q <= 1'b0;
            ped_s3_q <= 1'b0;
        end else begin
            car_s1_q <= sw_car;
            car_s2_q <= car_s1_q;
            ped_s1_q <= sw_ped;
            ped_s2_q <= ped_s1_q;
            ped_s3_q <= ped_s2_q;
        end
    end

    assign ped_rise = ped_s2_q & ~ped_s3_q;

`ifdef TL_FLASH_EN
    logic flash_s1_q, flash_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            flash_s1_q <= 1'b0;
            flash_s2_q <= 1'b0;
        end else begin
            flash_s1_q <= sw_flash;
            flash_s2_q <= flash_s1_q;
        end
    end

    assign flash_req = flash_s2_q;
`else
    logic sw_flash_unused;
    assign sw_flash_unused = sw_flash;
    assign flash_req       = 1'b0;
`endif

    // ------------------------------------------------------------- timebase
    logic tick;
    logic state_change;

    tl_tick_gen #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr_i (state_change),
        .tick_o(tick)
    );

    // ------------------------------------------------------------------ FSM
    tl_state_e  state_q, state_d;
    logic [7:0] sec_cnt_q, sec_cnt_d;
    logic       car_req_q, car_req_d;
    logic       ped_req_q, ped_req_d;
    logic       hb_q, hb_d;
    logic [7:0] led_q, led_d;
    logic [6:0] lights_d;
`ifdef TL_FLASH_EN
    logic       flash_lit_q, flash_lit_d;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_GREEN: begin
                // Flash select leaves green at once; otherwise wait for the
                // minimum green and a pending request, sampled on a tick.
                if (flash_req ||
                    (tick && (sec_cnt_q >= LAST_MIN_GREEN) && (car_req_q || ped_req_q))) begin
                    state_d = NS_YELLOW;
                end
            end
            NS_YELLOW: if (tick && sec_cnt_q == LAST_YELLOW) state_d = ALL_RED_A;
            ALL_RED_A: begin
                if (tick && sec_cnt_q == LAST_ALL_RED) begin
`ifdef TL_FLASH_EN
                    if (flash_req)      state_d = FLASH;
                    else if (car_req_q) state_d = EW_GREEN;
                    else                state_d = PED_WALK;
`else
                    if (car_req_q) state_d = EW_GREEN;
                    else           state_d = PED_WALK;
`endif
                end
            end
            EW_GREEN:  if (tick && sec_cnt_q == LAST_EW_GREEN) state_d = EW_YELLOW;
            EW_YELLOW: if (tick && sec_cnt_q == LAST_YELLOW) state_d = ALL_RED_B;
            ALL_RED_B: begin
                if (tick && sec_cnt_q == LAST_ALL_RED) begin
                    state_d = ped_req_q ? PED_WALK : NS_GREEN;
                end
            end
            PED_WALK:  if (tick && sec_cnt_q == LAST_WALK) state_d = NS_GREEN;
`ifdef TL_FLASH_EN
            FLASH:     if (!flash_req) state_d = ALL_RED_B;
`endif
            default:   state_d = ALL_RED_B;
        endcase
    end

    assign state_change = (state_d != state_q);

    always_comb begin
        sec_cnt_d = sec_cnt_q;
        if (state_change) begin
            sec_cnt_d = '0;
        end else if (tick && sec_cnt_q != '1) begin
            sec_cnt_d = sec_cnt_q + 8'd1;
        end

        car_req_d = car_req_q;
        if (car_s2_q && state_q != EW_GREEN) car_req_d = 1'b1;
        if (state_change && state_d == EW_GREEN) car_req_d = 1'b0;

        // A request already latched is served by this walk; an edge arriving
        // in the entry cycle itself is kept for the next walk.
        ped_req_d = ped_req_q;
        if (state_change && state_d == PED_WALK) ped_req_d = 1'b0;
        if (ped_rise) ped_req_d = 1'b1;

        hb_d = hb_q ^ tick;

        lights_d = lights_for(state_d);
`ifdef TL_FLASH_EN
        flash_lit_d = flash_lit_q;
        if (state_change && state_d == FLASH) begin
            flash_lit_d = 1'b1;
        end else if (state_q == FLASH && tick) begin
            flash_lit_d = ~flash_lit_q;
        end
        if (state_d == FLASH) begin
            lights_d = flash_lit_d ? LIGHTS_FLASH_LIT : LIGHTS_DARK;
        end
`endif

        led_d                = {1'b0, lights_d};
        led_d[LED_HEARTBEAT] = hb_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ALL_RED_B;
            sec_cnt_q   <= '0;
            car_req_q   <= 1'b0;
            ped_req_q   <= 1'b0;
            hb_q        <= 1'b0;
            led_q       <= {1'b0, LIGHTS_ALL_RED};
`ifdef TL_FLASH_EN
            flash_lit_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sec_cnt_q   <= sec_cnt_d;
            car_req_q   <= car_req_d;
            ped_req_q   <= ped_req_d;
            hb_q        <= hb_d;
            led_q       <= led_d;
`ifdef TL_FLASH_EN
            flash_lit_q <= flash_lit_d;
`endif
        end
    end

    assign led   = led_q;
    assign state = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb_traffic_light_ctrl - directed bench for traffic_light_ctrl with a
// 10-cycle tick. Lamp checks mask the heartbeat bit led[7].
module tb_traffic_light_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       sw_car;
    logic       sw_ped;
    logic       sw_flash;
    logic [7:0] led;
    logic [3:0] state;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    traffic_light_ctrl #(
        .CYCLES_PER_SEC(10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw_car  (sw_car),
        .sw_ped  (sw_ped),
        .sw_flash(sw_flash),
        .led     (led),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check led[6:0] against pat for n consecutive cycles.
    task automatic expect_seg(input string tag, input logic [6:0] pat, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            check(tag, 32'(led[6:0]), 32'(pat));
            step();
        end
    endtask

    // One reset edge, then the 10-cycle ALL_RED_B clearance; returns at NS green cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_led", 32'(led), 32'h24);
        check("rst_state", 32'(state), 32'd5);
        expect_seg("rst_red", 7'h24, 10);
        check("hb_first_tick", 32'(led[7]), 32'd1);
        check("green_state", 32'(state), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        sw_car   = 1'b0;
        sw_ped   = 1'b0;
        sw_flash = 1'b0;
        repeat (3) step();

        // Idle: NS green holds with no requests
        do_reset();
        expect_seg("idle_green", 7'h21, 500);
        check("idle_state", 32'(state), 32'd0);

        // Car pulse at green cycle 20 for 30 cycles
        do_reset();
        expect_seg("car_g0", 7'h21, 20);
        sw_car = 1'b1;
        expect_seg("car_g1", 7'h21, 30);
        sw_car = 1'b0;
        expect_seg("car_g2", 7'h21, 50);
        expect_seg("car_nsy", 7'h22, 30);
        expect_seg("car_ara", 7'h24, 10);
        check("car_ew_state", 32'(state), 32'd3);
        expect_seg("car_ewg", 7'h0C, 60);
        expect_seg("car_ewy", 7'h14, 30);
        expect_seg("car_arb", 7'h24, 10);
        expect_seg("car_back", 7'h21, 200);

        // Ped request after min green; edge in walk-entry cycle is retained;
        // edge during walk gives one more walk
        do_reset();
        expect_seg("ped_g0", 7'h21, 100);
        sw_ped = 1'b1;
        expect_seg("ped_g1", 7'h21, 10);
        sw_ped = 1'b0;
        expect_seg("ped_nsy", 7'h22, 30);
        expect_seg("ped_ara0", 7'h24, 7);
        sw_ped = 1'b1;
        expect_seg("ped_ara1", 7'h24, 3);
        sw_ped = 1'b0;
        check("walk1_state", 32'(state), 32'd6);
        expect_seg("walk1", 7'h64, 50);
        expect_seg("ped2_g", 7'h21, 100);
        expect_seg("ped2_nsy", 7'h22, 30);
        expect_seg("ped2_ara", 7'h24, 10);
        expect_seg("walk2a", 7'h64, 20);
        sw_ped = 1'b1;
        expect_seg("walk2b", 7'h64, 30);
        expect_seg("ped3_g", 7'h21, 100);
        expect_seg("ped3_nsy", 7'h22, 30);
        expect_seg("ped3_ara", 7'h24, 10);
        expect_seg("walk3", 7'h64, 50);
        sw_ped = 1'b0;
        expect_seg("ped_done", 7'h21, 150);

        // Car and ped together: EW served first, then walk, then NS
        do_reset();
        expect_seg("both_g0", 7'h21, 100);
        sw_car = 1'b1;
        sw_ped = 1'b1;
        expect_seg("both_g1", 7'h21, 10);
        sw_car = 1'b0;
        sw_ped = 1'b0;
        expect_seg("both_nsy", 7'h22, 30);
        expect_seg("both_ara", 7'h24, 10);
        expect_seg("both_ewg", 7'h0C, 60);
        expect_seg("both_ewy", 7'h14, 30);
        expect_seg("both_arb", 7'h24, 10);
        expect_seg("both_walk", 7'h64, 50);
        expect_seg("both_done", 7'h21, 150);

`ifdef TL_FLASH_EN
        // Night flash from NS green cycle 5
        do_reset();
        expect_seg("fl_g0", 7'h21, 5);
        sw_flash = 1'b1;
        expect_seg("fl_g1", 7'h21, 3);
        expect_seg("fl_nsy", 7'h22, 30);
        expect_seg("fl_ara", 7'h24, 10);
        check("fl_state", 32'(state), 32'd7);
        expect_seg("fl_on0", 7'h22, 10);
        expect_seg("fl_off0", 7'h00, 10);
        expect_seg("fl_on1", 7'h22, 10);
        expect_seg("fl_off1", 7'h00, 10);
        sw_flash = 1'b0;
        expect_seg("fl_exit", 7'h22, 3);
        expect_seg("fl_arb", 7'h24, 10);
        expect_seg("fl_green", 7'h21, 20);
`endif

        // Reset mid EW green with a ped request pending
        do_reset();
        sw_car = 1'b1;
        expect_seg("rm_g0", 7'h21, 10);
        sw_car = 1'b0;
        expect_seg("rm_g1", 7'h21, 90);
        expect_seg("rm_nsy", 7'h22, 30);
        expect_seg("rm_ara", 7'h24, 10);
        check("rm_ew_state", 32'(state), 32'd3);
        expect_seg("rm_ew0", 7'h0C, 5);
        sw_ped = 1'b1;
        expect_seg("rm_ew1", 7'h0C, 5);
        sw_ped = 1'b0;
        expect_seg("rm_ew2", 7'h0C, 10);
        do_reset();
        expect_seg("rm_after", 7'h21, 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
